// File: rtl/adder_input_sequencer.sv
// Full-adder front end: sync/debounce button and switch, step A/B/Cin entry, scan four digits.
// Press appears DEBOUNCE_CYCLES+3 edges after a clean button rise; no backpressure, scan free-runs.
module adder_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic [3:0] value,
  output logic [3:0] digit_an,
  output logic       press,
  output logic       result_valid
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {GET_A = 2'd0, GET_B = 2'd1, GET_CIN = 2'd2, SHOW = 2'd3} state_t;

  logic          btn_m_q, btn_s_q, sw_m_q, sw_s_q;
  logic          btn_db_q, btn_db_d, btn_db_prev_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;
  state_t        state_q, state_d;
  logic          a_q, a_d, b_q, b_d, cin_q, cin_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic [1:0]    res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m_q       <= 1'b0;
      btn_s_q       <= 1'b0;
      sw_m_q        <= 1'b0;
      sw_s_q        <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      press_q       <= 1'b0;
      a_q           <= 1'b0;
      b_q           <= 1'b0;
      cin_q         <= 1'b0;
      scan_cnt_q    <= '0;
      digit_sel_q   <= 2'd0;
    end else begin
      btn_m_q       <= btn_raw;
      btn_s_q       <= btn_m_q;
      sw_m_q        <= sw_raw;
      sw_s_q        <= sw_m_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      press_q       <= press_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cin_q         <= cin_d;
      scan_cnt_q    <= scan_cnt_d;
      digit_sel_q   <= digit_sel_d;
    end
  end

  // Any agreement between btn_s and the accepted level restarts the stability count.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = btn_db_q & ~btn_db_prev_q;
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d  = '0;
      digit_sel_d = digit_sel_q + 2'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= GET_A;
    else     state_q <= state_d;
  end

  // FSM: next state and operand capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    if (press_q) begin
      unique case (state_q)
        GET_A:   begin a_d   = sw_s_q; state_d = GET_B;   end
        GET_B:   begin b_d   = sw_s_q; state_d = GET_CIN; end
        GET_CIN: begin cin_d = sw_s_q; state_d = SHOW;    end
        SHOW:    begin a_d = 1'b0; b_d = 1'b0; cin_d = 1'b0; state_d = GET_A; end
        default: state_d = GET_A;
      endcase
    end
  end

  assign res = {1'b0, a_q} + {1'b0, b_q} + {1'b0, cin_q};

  // FSM: outputs, decoded from registered state so anode and value always agree
  always_comb begin
    value        = BLANK;
    digit_an     = ~(4'b0001 << digit_sel_q);
    result_valid = (state_q == SHOW);
    press        = press_q;
    unique case (digit_sel_q)
      2'd0: value = (state_q == GET_A) ? {3'b0, sw_s_q} : {3'b0, a_q};
      2'd1: begin
        if (state_q == GET_B)      value = {3'b0, sw_s_q};
        else if (state_q != GET_A) value = {3'b0, b_q};
      end
      2'd2: begin
        if (state_q == GET_CIN)   value = {3'b0, sw_s_q};
        else if (state_q == SHOW) value = {3'b0, cin_q};
      end
      2'd3: if (state_q == SHOW) value = {2'b0, res};
      default: value = BLANK;
    endcase
  end

endmodule

// File: doc/adder_input_sequencer.md
# adder_input_sequencer

Front-end controller for the full-adder display: takes one raw push button and one raw slide switch, synchronizes and debounces them, and lets the user enter operands A, B and Cin one press at a time. It then computes the full-adder result. The block time-multiplexes four digits onto the 4-bit `value` bus that feeds the existing `seven_segment` decoder, and drives the active-low digit anodes. Code 4'hF is the blank code; the decoder's default branch renders it as all segments off.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required to accept a new button level (>= 2).
- `SCAN_CYCLES`, default 8: clock cycles each digit is shown before advancing (>= 2).

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  1  raw push button, active-high, asynchronous to `clk`, bouncy.
- `sw_raw`  in  1  raw slide switch, asynchronous to `clk`.
- `value`  out  4  code for the currently selected digit, to `seven_segment`.
- `digit_an`  out  4  active-low one-hot anode enable; bit i low means digit i is selected.
- `press`  out  1  one-cycle debounced press pulse (observability).
- `result_valid`  out  1  high while in state SHOW.

## Operation
- **Synchronizers:** each of `btn_raw` and `sw_raw` passes through a 2-flop synchronizer, giving `btn_s` and `sw_s`.
- **Debounce:**
  - `btn_db` holds the accepted level.
  - The counter clears whenever `btn_s == btn_db`; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while `btn_s != btn_db`, then on that edge `btn_db <= btn_s` and the counter clears.
  - Width of the counter is clog2(DEBOUNCE_CYCLES).
- **Press pulse:** `press` is a registered rising-edge detect of `btn_db` and is high for exactly 1 cycle. Release is debounced identically. Holding the button yields exactly one press.
- **FSM:** states GET_A, GET_B, GET_CIN, SHOW. Transitions happen only on `press`:
  - GET_A→GET_B: captures `a <= sw_s`.
  - GET_B→GET_CIN: captures `b <= sw_s`.
  - GET_CIN→SHOW: captures `cin <= sw_s`.
  - SHOW→GET_A: clears a, b and cin to 0.
  - Capture uses `sw_s` in the same cycle `press` is high.
- **Arithmetic:** `res = a + b + cin`, 2 bits {cout, sum}, range 0..3, zero-extended to 4 bits for display.
- **Digit mapping:** digit 0 shows A, digit 1 shows B, digit 2 shows Cin, digit 3 shows the result.
  - The digit currently being entered shows the live `{3'b0, sw_s}`.
  - Captured digits show their stored bit.
  - Not-yet-reached digits show 4'hF.
  - Digit 3 shows `res` only in SHOW; otherwise it shows 4'hF.
- **Scan:**
  - `scan_cnt` counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, `digit_sel` (2 bits) increments mod 4 (3→0).
  - `digit_an = ~(4'b0001 << digit_sel)`.
  - `value` and `digit_an` are combinational decodes of registered state, so they always refer to the same digit in the same cycle.

## Timing
- **Reset values (async, immediate):**
  - Synchronizers, `btn_db`, debounce counter, `press`: 0.
  - State: GET_A. a, b, cin: 0.
  - `scan_cnt` 0, `digit_sel` 0.
  - Resulting outputs: `digit_an` 4'b1110, `value` 4'h0 (live `sw_s` = 0 on the digit being entered), `press` 0, `result_valid` 0.
- **Press latency:** with `btn_raw` rising before edge 1 and held, `btn_s` is high after edge 2 and `btn_db` after edge 2+DEBOUNCE_CYCLES. `press` is high for the cycle following edge 3+DEBOUNCE_CYCLES. The state changes at the next edge.
- **Switch latency:** `sw_raw` reaches `sw_s`, and therefore `value`, after 2 edges. The switch is not debounced; capture is level-at-press.
- **Bounce:**
  - A `btn_s` pulse shorter than DEBOUNCE_CYCLES cycles produces no `press`.
  - Any return of `btn_s` to `btn_db` restarts the count.
- **Scan timing:**
  - Each digit is held exactly SCAN_CYCLES cycles.
  - A full rotation takes 4*SCAN_CYCLES cycles.
  - Scanning continues across state changes and is never stalled.
- **Simultaneous events:** a state change coinciding with a digit change is fine; `value` reflects the new state and new digit in the same cycle.
- **Reset mid-operation:** from any state, `rst` discards captured operands and any partial debounce. After release, a button still held is not a press until `btn_db` first goes high; that rising edge does count as a press.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `sw_raw`=1 → during reset `digit_an`=4'b1110, `value`=4'h0, `press`=0, `result_valid`=0. After 2 edges post-release, `value` on digit 0 = 4'h1.
- **Full entry 1,1,1:** DEBOUNCE_CYCLES=16, SCAN_CYCLES=8; three clean presses (held 40 cycles, released 40) with `sw_raw`=1 → `press` pulses exactly 3 times, `result_valid`=1, digits 0..3 show 1,1,1,4'h3.
- **Entry 1,0,0:** → digit 3 shows 4'h1. After a fourth press → GET_A, digits 1..3 show 4'hF, `result_valid`=0.
- **Bounce rejection and hold:**
  - `btn_raw` high for 15 cycles then low → no `press`.
  - Toggling every 5 cycles for 60 cycles, then held high for 100 → exactly one `press`, 19 cycles after the final rise.
- **Scan rotation:** observe 40 cycles → `digit_an` sequence 1110, 1101, 1011, 0111, 1110, each held 8 cycles, with `value` consistent with the mapping every cycle.
- **Async reset mid-entry:** assert `rst` between clock edges while in GET_CIN → outputs return to reset values before the next edge, and the next presses restart at A.
